// File: rtl/cpu_out_display_pkg.sv
// Shared constants for the Aeolus cpuOut history display: digit count and
// active-low {g,f,e,d,c,b,a} hex font.
package aeolus_disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_HEX_A = 7'h08;
  localparam logic [SEG_W-1:0] SEG_HEX_B = 7'h03;  // lower-case b
  localparam logic [SEG_W-1:0] SEG_HEX_C = 7'h46;
  localparam logic [SEG_W-1:0] SEG_HEX_D = 7'h21;  // lower-case d
  localparam logic [SEG_W-1:0] SEG_HEX_E = 7'h06;
  localparam logic [SEG_W-1:0] SEG_HEX_F = 7'h0E;

endpackage

// File: rtl/cpu_out_display_hex_to_seg7.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module hex_to_seg7
  import aeolus_disp_pkg::*;
(
  input  logic [NIB_W-1:0] i_nibble,
  output logic [SEG_W-1:0] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_BLANK;
    case (i_nibble)
      4'h0:    o_seg_c = SEG_HEX_0;
      4'h1:    o_seg_c = SEG_HEX_1;
      4'h2:    o_seg_c = SEG_HEX_2;
      4'h3:    o_seg_c = SEG_HEX_3;
      4'h4:    o_seg_c = SEG_HEX_4;
      4'h5:    o_seg_c = SEG_HEX_5;
      4'h6:    o_seg_c = SEG_HEX_6;
      4'h7:    o_seg_c = SEG_HEX_7;
      4'h8:    o_seg_c = SEG_HEX_8;
      4'h9:    o_seg_c = SEG_HEX_9;
      4'hA:    o_seg_c = SEG_HEX_A;
      4'hB:    o_seg_c = SEG_HEX_B;
      4'hC:    o_seg_c = SEG_HEX_C;
      4'hD:    o_seg_c = SEG_HEX_D;
      4'hE:    o_seg_c = SEG_HEX_E;
      4'hF:    o_seg_c = SEG_HEX_F;
      default: o_seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cpu_out_display.sv
// Captures distinct consecutive cpuOut values into a 4-deep history and scans it
// onto a 4-digit common-anode display. Define DISP_HISTORY_BLANK_EN to blank unfilled slots.
module cpu_out_display
  import aeolus_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 25000
) (
  input  logic             boardCLK,
  input  logic             reset,
  input  logic [NIB_W-1:0] cpuOut,
  input  logic             hold,
  output logic [SEG_W-1:0] seg,
  output logic             dp,
  output logic [3:0]       an,
  output logic [NIB_W-1:0] latestValue,
  output logic             updatePulse
);

  localparam int unsigned DIV_W = 20;

  logic [NIB_W-1:0] r_hist [NUM_DIGITS];
  logic [3:0]       r_valid;
  logic             r_update;
  logic [DIV_W-1:0] r_div_cnt;
  logic [1:0]       r_digit_idx;
  logic [3:0]       r_an;
  logic [SEG_W-1:0] r_seg;
  logic             r_dp;

  logic             w_capture;
  logic [NIB_W-1:0] w_sel_nib;
  logic [SEG_W-1:0] w_hex_seg;
  logic [SEG_W-1:0] w_seg_nxt;
  logic             w_dp_nxt;

  assign w_capture = !hold && (!r_valid[0] || (cpuOut != r_hist[0]));

  // History shift register; valid saturates once all four slots are filled.
  always_ff @(posedge boardCLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) r_hist[i] <= '0;
      r_valid  <= '0;
      r_update <= 1'b0;
    end else begin
      r_update <= w_capture;
      if (w_capture) begin
        for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) r_hist[i] <= r_hist[i-1];
        r_hist[0] <= cpuOut;
        r_valid   <= r_valid[3] ? r_valid : {r_valid[2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge boardCLK or posedge reset) begin
    if (reset) begin
      r_div_cnt   <= '0;
      r_digit_idx <= '0;
    end else if (r_div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      r_div_cnt   <= '0;
      r_digit_idx <= r_digit_idx + 2'd1;
    end else begin
      r_div_cnt   <= r_div_cnt + DIV_W'(1);
    end
  end

  assign w_sel_nib = r_hist[r_digit_idx];

  hex_to_seg7 u_hex_to_seg7 (
    .i_nibble (w_sel_nib),
    .o_seg_c  (w_hex_seg)
  );

  // dp marks the newest entry, which always sits in digit 0.
  always_comb begin
    w_seg_nxt = w_hex_seg;
    w_dp_nxt  = (r_digit_idx != 2'd0);
`ifdef DISP_HISTORY_BLANK_EN
    if (!r_valid[r_digit_idx]) begin
      w_seg_nxt = SEG_BLANK;
      w_dp_nxt  = 1'b1;
    end
`endif
  end

  always_ff @(posedge boardCLK or posedge reset) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << r_digit_idx);
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign seg         = r_seg;
  assign dp          = r_dp;
  assign an          = r_an;
  assign latestValue = r_hist[0];
  assign updatePulse = r_update;

endmodule

// File: tb/tb_cpu_out_display.sv
// Bench for cpu_out_display: two instances (SCAN_DIV=4 and 1) checked against a queue-based model.
module tb_cpu_out_display;

  logic       boardCLK;
  logic       reset;
  logic [3:0] cpuOut;
  logic       hold;

  logic [6:0] seg4, seg1;
  logic       dp4, dp1;
  logic [3:0] an4, an1;
  logic [3:0] lat4, lat1;
  logic       up4, up1;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_out_display #(.SCAN_DIV(4)) dut4 (
    .boardCLK(boardCLK), .reset(reset), .cpuOut(cpuOut), .hold(hold),
    .seg(seg4), .dp(dp4), .an(an4), .latestValue(lat4), .updatePulse(up4)
  );

  cpu_out_display #(.SCAN_DIV(1)) dut1 (
    .boardCLK(boardCLK), .reset(reset), .cpuOut(cpuOut), .hold(hold),
    .seg(seg1), .dp(dp1), .an(an1), .latestValue(lat1), .updatePulse(up1)
  );

  initial boardCLK = 1'b0;
  always #5 boardCLK = ~boardCLK;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Active-high gfedcba glyphs; the display wants their complement.
  localparam logic [6:0] GLYPH_ON [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [6:0] font(input int v);
    return ~GLYPH_ON[v];
  endfunction

  // Behavioural model: history as a newest-first list plus a count of filled slots.
  int         m_hist[4];
  int         m_nvalid;
  int         m_cyc;
  logic [3:0] e_an[2];
  logic [6:0] e_seg[2];
  logic       e_dp[2];
  logic       e_pulse;
  logic [3:0] e_latest;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_hist[i] = 0;
    m_nvalid = 0;
    m_cyc    = 0;
    for (int k = 0; k < 2; k++) begin
      e_an[k]  = 4'b1111;
      e_seg[k] = 7'h7F;
      e_dp[k]  = 1'b1;
    end
    e_pulse  = 1'b0;
    e_latest = 4'h0;
  endtask

  task automatic model_edge();
    int  d, idx;
    bit  blank, cap;
    if (reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      d   = (k == 0) ? 4 : 1;
      idx = (m_cyc / d) % 4;
      e_an[k] = ~(4'b0001 << idx);
`ifdef DISP_HISTORY_BLANK_EN
      blank = (idx >= m_nvalid);
`else
      blank = 1'b0;
`endif
      e_seg[k] = blank ? 7'h7F : font(m_hist[idx]);
      e_dp[k]  = blank || (idx != 0);
    end
    cap = !hold && (m_nvalid == 0 || int'(cpuOut) != m_hist[0]);
    if (cap) begin
      for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = int'(cpuOut);
      if (m_nvalid < 4) m_nvalid++;
    end
    e_pulse  = cap;
    e_latest = 4'(m_hist[0]);
    m_cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("an_div4",  32'(an4),  32'(e_an[0]));
    chk("seg_div4", 32'(seg4), 32'(e_seg[0]));
    chk("dp_div4",  32'(dp4),  32'(e_dp[0]));
    chk("an_div1",  32'(an1),  32'(e_an[1]));
    chk("seg_div1", 32'(seg1), 32'(e_seg[1]));
    chk("dp_div1",  32'(dp1),  32'(e_dp[1]));
    chk("pulse4",   32'(up4),  32'(e_pulse));
    chk("pulse1",   32'(up1),  32'(e_pulse));
    chk("latest4",  32'(lat4), 32'(e_latest));
    chk("latest1",  32'(lat1), 32'(e_latest));
  endtask

  task automatic step();
    @(posedge boardCLK);
    model_edge();
    #1;
    compare_all();
  endtask

  typedef struct {
    logic       h;
    logic [3:0] v;
    logic       exp_pulse;
    logic [3:0] exp_latest;
  } vec_t;

  vec_t vecs[12];
  int   pulse_cnt;
  int   run_len;
  logic [3:0] prev_an;
  logic [6:0] exp_unfilled;

  initial begin
    vecs[0]  = '{1'b0, 4'h1, 1'b1, 4'h1};
    vecs[1]  = '{1'b0, 4'h1, 1'b0, 4'h1};
    vecs[2]  = '{1'b0, 4'h2, 1'b1, 4'h2};
    vecs[3]  = '{1'b0, 4'h3, 1'b1, 4'h3};
    vecs[4]  = '{1'b0, 4'h4, 1'b1, 4'h4};
    vecs[5]  = '{1'b0, 4'h5, 1'b1, 4'h5};
    vecs[6]  = '{1'b0, 4'h7, 1'b1, 4'h7};
    vecs[7]  = '{1'b1, 4'h9, 1'b0, 4'h7};
    vecs[8]  = '{1'b1, 4'h9, 1'b0, 4'h7};
    vecs[9]  = '{1'b0, 4'h9, 1'b1, 4'h9};
    vecs[10] = '{1'b0, 4'h9, 1'b0, 4'h9};
    vecs[11] = '{1'b0, 4'h0, 1'b1, 4'h0};

    reset  = 1'b1;
    cpuOut = 4'h5;
    hold   = 1'b0;
    model_reset();
    repeat (3) step();
    chk("rst_an",  32'(an4),  32'h0000000F);
    chk("rst_seg", 32'(seg4), 32'h0000007F);
    chk("rst_dp",  32'(dp4),  32'h1);
    chk("rst_up",  32'(up4),  32'h0);

    reset = 1'b0;
    step();
    chk("first_pulse",  32'(up4),  32'h1);
    chk("first_latest", 32'(lat4), 32'h5);

    // Distinct-value sequence, then a held change released later.
    pulse_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      hold   = vecs[i].h;
      cpuOut = vecs[i].v;
      step();
      if (i < 6) pulse_cnt += int'(up4);
      chk($sformatf("vec%0d_pulse", i),  32'(up4),  32'(vecs[i].exp_pulse));
      chk($sformatf("vec%0d_latest", i), 32'(lat4), 32'(vecs[i].exp_latest));
      if (i == 5) begin
        chk("seq_pulse_count", 32'(pulse_cnt), 32'd5);
        hold = 1'b1;
        for (int c = 0; c < 20; c++) begin
          step();
          if (an4 == 4'b1110) begin
            chk("seq_d0_seg", 32'(seg4), 32'h12);
            chk("seq_d0_dp",  32'(dp4),  32'h0);
          end
          if (an4 == 4'b0111) chk("seq_d3_seg", 32'(seg4), 32'h24);
        end
      end
    end

    // Each anode pattern of the SCAN_DIV=4 instance must persist exactly 4 cycles.
    hold = 1'b1;
    prev_an = an4;
    run_len = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (an4 == prev_an) run_len++;
      else begin
        if (c > 4) chk("scan_run_len", 32'(run_len), 32'd3);
        run_len = 0;
        prev_an = an4;
      end
    end

    // Mid-scan asynchronous reset, checked before the next edge.
    hold = 1'b0;
    cpuOut = 4'hC;
    step();
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("arst_an",     32'(an4),  32'hF);
    chk("arst_seg",    32'(seg4), 32'h7F);
    chk("arst_dp",     32'(dp1),  32'h1);
    chk("arst_latest", 32'(lat1), 32'h0);
    chk("arst_pulse",  32'(up1),  32'h0);
    step();
    reset  = 1'b0;
    cpuOut = 4'h3;
    step();
    chk("rearm_pulse", 32'(up1), 32'h1);
`ifdef DISP_HISTORY_BLANK_EN
    exp_unfilled = 7'h7F;
`else
    exp_unfilled = font(0);
`endif
    for (int c = 0; c < 8; c++) begin
      step();
      if (an1 != 4'b1110) chk("unfilled_seg", 32'(seg1), 32'(exp_unfilled));
      else                chk("filled_seg",   32'(seg1), 32'(font(3)));
    end

    // Randomised traffic with occasional holds and rare resets.
    for (int c = 0; c < 500; c++) begin
      hold   = ($urandom_range(0, 3) == 0);
      cpuOut = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      reset  = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_out_display.md
Name: cpu_out_display

Overview:
Downstream consumer of the Aeolus CPU top's 4-bit cpuOut. Captures each new cpuOut value into a 4-entry history (newest first) and drives a 4-digit, time-multiplexed, common-anode 7-segment display with the history in hex. Sits beside AeolusCPUTop on the board, clocked by the same boardCLK. It also exposes the latest captured value and a one-cycle update strobe for other consumers.

Parameters:
SCAN_DIV, 25000, boardCLK cycles each digit stays lit; legal range 1..2^20.
NUM_DIGITS, 4, fixed at 4; present for package consistency only; other values illegal.

Ports:
boardCLK  in   1  system clock, shared with CPU.
reset     in   1  asynchronous, active-high; clears all state.
cpuOut    in   4  CPU output, synchronous to boardCLK.
hold      in   1  when 1, inhibits capture; scanning continues.
seg       out  7  segments {g,f,e,d,c,b,a}, active-low.
dp        out  1  decimal point, active-low.
an        out  4  digit anodes, active-low; an[0] is the rightmost digit.
latestValue out 4  newest captured value (history[0]).
updatePulse out 1  high for one cycle after each capture.

Behaviour:
- Reset (async assert, sync-to-clock release): history[0..3]=0, valid=4'b0000, divCnt=0, digitIdx=0, an=4'b1111, seg=7'h7F, dp=1, latestValue=0, updatePulse=0. Asserting reset mid-scan or mid-capture clears everything immediately; there are no partial updates.
- Capture condition, evaluated each cycle: !hold && (valid[0]==0 || cpuOut != history[0]).
- On capture at edge N:
  - history shifts: history[3]<=history[2], history[2]<=history[1], history[1]<=history[0], history[0]<=cpuOut.
  - valid <= {valid[2:0],1'b1}.
- updatePulse is 1 in the cycle after edge N (registered). latestValue equals history[0].
- The first cycle after reset release always captures, because valid[0]=0, including cpuOut=0.
- A repeated identical value is not captured. The history holds distinct consecutive values only.
- hold=1 with a simultaneous change: no capture. If the value still differs when hold drops, it is captured on the first cycle with hold=0.
- History saturates at 4 entries; the oldest entry is discarded. valid stays 4'b1111.
- Scan divider:
  - divCnt counts 0..SCAN_DIV-1.
  - When divCnt==SCAN_DIV-1: divCnt<=0 and digitIdx<=digitIdx+1, wrapping 3->0.
  - With SCAN_DIV=1, digitIdx advances every cycle.
- Display outputs are registered from digitIdx and history, so they lag digitIdx by one cycle and an/seg/dp always change on the same edge.
  - an = ~(4'b0001 << digitIdx).
  - seg = hex font of history[digitIdx], glyphs 0-9 and A-F, lower-case b and d.
  - dp = 0 only when digitIdx==0 (marks newest), else 1.
- Digit slot whose valid bit is 0: behaviour depends on the optional feature below.
- A capture changes the displayed digit at most 2 cycles after cpuOut changes (capture edge, then display register edge), provided that digit is selected.

Optional Feature:
Macro DISP_HISTORY_BLANK_EN.
- Defined: a digit with valid[i]=0 drives seg=7'h7F (blank), and its dp stays 1 even for digit 0.
- Undefined: invalid slots display their reset content "0" normally. There is no valid-based gating; the valid register is still kept for capture logic.

Decomposition:
- Package aeolus_disp_pkg holds:
  - NUM_DIGITS=4.
  - SEG_BLANK=7'h7F.
  - The 16-entry active-low hex font constants SEG_HEX_0..SEG_HEX_F.
- One natural sub-module: hex_to_seg7, a combinational 4-bit to 7-bit active-low decoder using the package constants. The scan counter and history stay in cpu_out_display.

Test Plan:
- Reset hold: reset=1, cpuOut=4'h5 -> an=4'b1111, seg=7'h7F, dp=1, updatePulse=0. Release reset -> capture of 5 on the first edge, updatePulse=1 one cycle later, latestValue=4'h5.
- Sequence: with SCAN_DIV=4, cpuOut 1,1,2,3,4,5 (one cycle each) -> exactly 5 updatePulses. Final history {5,4,3,2}. Scanning shows digit0 seg=SEG_HEX_5 with dp=0, and digit3 seg=SEG_HEX_2.
- Scan timing: SCAN_DIV=4 -> an cycles 1110,1101,1011,0111 with each pattern held exactly 4 cycles, wrapping back to 1110. Also run SCAN_DIV=1 -> pattern changes every cycle.
- Hold: hold=1, cpuOut 7->9 -> no updatePulse and latestValue unchanged. Drop hold -> capture of 9 on the next edge.
- Blanking: with DISP_HISTORY_BLANK_EN defined, after one capture -> digits 1-3 seg=7'h7F. Without the macro -> digits 1-3 seg=SEG_HEX_0.
- Mid-operation reset: assert reset asynchronously between edges during a scan -> outputs reach reset values before the next edge. After release, history restarts with valid=4'b0001 after the first capture.
